// File: rtl/nexys_starship_repair_bank_pkg.sv
// Shared state encodings and helpers for the starship repair bank.
package nexys_starship_repair_bank_pkg;

  typedef enum logic [1:0] {
    GInit   = 2'b01,
    GActive = 2'b10
  } glb_state_e;

  typedef enum logic [2:0] {
    SlCooldown = 3'b001,
    SlArmed    = 3'b010,
    SlBroken   = 3'b100
  } slot_state_e;

  function automatic int unsigned popcount8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/nexys_starship_repair_slot.sv
// One repairable part: cooldown/armed/broken FSM, tick counter and latched combo.
// With NEXYS_STARSHIP_REPAIR_TIMEOUT_EN the tick counter also times the BROKEN state.
module nexys_starship_repair_slot
  import nexys_starship_repair_bank_pkg::*;
#(
  parameter int unsigned ComboW        = 4,
  parameter int unsigned DelayW        = 8,
  parameter int unsigned BreakDelay    = 1,
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  parameter int unsigned RepairTimeout = 16,
`endif
  parameter int unsigned SlotIdx       = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic              grant_i,
  input  logic [ComboW-1:0] random_hex_i,
  input  logic [ComboW-1:0] hex_combo_i,
  input  logic              submit_i,
  output logic              armed_o,
  output logic              broken_o,
  output logic [ComboW-1:0] combo_o,
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic              repair_evt_o,
  output logic              wrong_evt_o
);

  localparam logic [ComboW-1:0] IdxMask  = ComboW'(SlotIdx);
  localparam logic [DelayW-1:0] BreakCnt = DelayW'(BreakDelay);
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  localparam logic [DelayW-1:0] TimeoutCnt = DelayW'(RepairTimeout);
`endif

  slot_state_e       state_q, state_d;
  logic [DelayW-1:0] cnt_q, cnt_d;
  logic [ComboW-1:0] combo_q, combo_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    combo_d      = combo_q;
    repair_evt_o = 1'b0;
    wrong_evt_o  = 1'b0;
    if (clear_i) begin
      state_d = SlCooldown;
      cnt_d   = '0;
      combo_d = '0;
    end else begin
      unique case (state_q)
        SlCooldown: begin
          // Compared every cycle so BreakDelay == 0 arms without waiting for a tick.
          if (cnt_q == BreakCnt) begin
            state_d = SlArmed;
            cnt_d   = '0;
          end else if (tick_i) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SlArmed: begin
          if (grant_i) begin
            state_d = SlBroken;
            combo_d = random_hex_i ^ IdxMask;
          end
        end
        SlBroken: begin
          if (submit_i) begin
            if (hex_combo_i == combo_q) begin
              state_d      = SlCooldown;
              cnt_d        = '0;
              repair_evt_o = 1'b1;
            end else begin
              wrong_evt_o = 1'b1;
            end
          end
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
          if (state_d == SlBroken && tick_i && cnt_q != TimeoutCnt) begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = SlCooldown;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SlCooldown;
      cnt_q   <= '0;
      combo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      combo_q <= combo_d;
    end
  end

  assign armed_o  = (state_q == SlArmed);
  assign broken_o = (state_q == SlBroken);
  assign combo_o  = combo_q;
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  assign timeout_o = (state_q == SlBroken) && (cnt_q == TimeoutCnt);
`endif

endmodule

// File: rtl/nexys_starship_repair_bank.sv
// Repair controller for NUM_PARTS starship parts: global FSM, break grants, repair counter.
// Optional per-part repair timeout is enabled by NEXYS_STARSHIP_REPAIR_TIMEOUT_EN.
module nexys_starship_repair_bank
  import nexys_starship_repair_bank_pkg::*;
#(
  parameter int unsigned NUM_PARTS      = 4,
  parameter int unsigned COMBO_W        = 4,
  parameter int unsigned DELAY_W        = 8,
  parameter int unsigned BREAK_DELAY    = 1,
  parameter int unsigned MAX_BROKEN     = 2,
  parameter int unsigned REPAIR_TIMEOUT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         timer_tick_i,
  input  logic                         play_flag_i,
  input  logic                         gameover_ctrl_i,
  input  logic [NUM_PARTS-1:0]         break_random_i,
  input  logic [COMBO_W-1:0]           random_hex_i,
  input  logic [COMBO_W-1:0]           hex_combo_i,
  input  logic [NUM_PARTS-1:0]         submit_i,
  output logic                         q_init_o,
  output logic                         q_active_o,
  output logic [NUM_PARTS-1:0]         broken_o,
  output logic [NUM_PARTS*COMBO_W-1:0] combo_o,
  output logic [NUM_PARTS-1:0]         repair_done_o,
  output logic [NUM_PARTS-1:0]         wrong_guess_o,
  output logic [7:0]                   repair_count_o,
  output logic                         gameover_req_o
);

  if (NUM_PARTS < 1 || NUM_PARTS > 8 || MAX_BROKEN < 1 || MAX_BROKEN > NUM_PARTS ||
      BREAK_DELAY >= 2 ** DELAY_W || REPAIR_TIMEOUT >= 2 ** DELAY_W) begin : g_bad_params
    $error("nexys_starship_repair_bank: parameter out of range");
  end

  glb_state_e           state_q, state_d;
  logic                 active, clear;
  logic [NUM_PARTS-1:0] armed, grant, repair_evt, wrong_evt;
  logic [NUM_PARTS-1:0] repair_done_q, wrong_guess_q;
  logic [7:0]           repair_count_q, repair_count_d;
  int unsigned          used_cnt, count_sum;

  assign active = (state_q == GActive);
  // gameover wins over every same-cycle slot event, so it clears just like INIT.
  assign clear  = !active || gameover_ctrl_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GInit:   if (play_flag_i && !gameover_ctrl_i) state_d = GActive;
      GActive: if (gameover_ctrl_i) state_d = GInit;
      default: state_d = GInit;
    endcase
  end

  // Lowest index first; repairs this cycle do not free a slot until the next cycle.
  always_comb begin
    grant    = '0;
    used_cnt = popcount8(8'(broken_o));
    for (int i = 0; i < NUM_PARTS; i++) begin
      if (armed[i] && break_random_i[i] && used_cnt < MAX_BROKEN) begin
        grant[i] = 1'b1;
        used_cnt = used_cnt + 1;
      end
    end
  end

  always_comb begin
    count_sum      = 32'(repair_count_q) + popcount8(8'(repair_evt));
    repair_count_d = (count_sum > 255) ? 8'hff : 8'(count_sum);
    if (clear) repair_count_d = '0;
  end

`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  logic [NUM_PARTS-1:0] timeout;
`endif

  for (genvar i = 0; i < NUM_PARTS; i++) begin : g_slot
    nexys_starship_repair_slot #(
      .ComboW       (COMBO_W),
      .DelayW       (DELAY_W),
      .BreakDelay   (BREAK_DELAY),
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
      .RepairTimeout(REPAIR_TIMEOUT),
`endif
      .SlotIdx      (i)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear),
      .tick_i      (timer_tick_i),
      .grant_i     (grant[i]),
      .random_hex_i(random_hex_i),
      .hex_combo_i (hex_combo_i),
      .submit_i    (submit_i[i]),
      .armed_o     (armed[i]),
      .broken_o    (broken_o[i]),
      .combo_o     (combo_o[i*COMBO_W +: COMBO_W]),
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
      .timeout_o   (timeout[i]),
`endif
      .repair_evt_o(repair_evt[i]),
      .wrong_evt_o (wrong_evt[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= GInit;
      repair_done_q  <= '0;
      wrong_guess_q  <= '0;
      repair_count_q <= '0;
    end else begin
      state_q        <= state_d;
      repair_done_q  <= repair_evt;
      wrong_guess_q  <= wrong_evt;
      repair_count_q <= repair_count_d;
    end
  end

`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
  logic gameover_req_q, gameover_req_d;
  assign gameover_req_d = clear ? 1'b0 : (gameover_req_q | (|timeout));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gameover_req_q <= 1'b0;
    else         gameover_req_q <= gameover_req_d;
  end

  assign gameover_req_o = gameover_req_q;
`else
  assign gameover_req_o = 1'b0;
`endif

  assign q_init_o       = (state_q == GInit);
  assign q_active_o     = active;
  assign repair_done_o  = repair_done_q;
  assign wrong_guess_o  = wrong_guess_q;
  assign repair_count_o = repair_count_q;

endmodule
